// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
// Control bundle layout used by ID/EX, EX/MEM and the forwarding unit.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CTRL_W     = 9;

    localparam int REGWRITE  = 8;
    localparam int MEMREAD   = 7;
    localparam int MEMWRITE  = 6;
    localparam int MEMTOREG  = 5;
    localparam int ALUSRC    = 4;
    localparam int REGDST    = 3;
    localparam int ALUOP_MSB = 2;
    localparam int ALUOP_LSB = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the ID instruction
// and a load sitting in EX.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt_addr,
    output logic              hazard
);

    logic load_live;
    logic rs_hit;
    logic rt_hit;

    assign load_live = id_valid & ex_valid & ex_mem_read
                     & (ex_rt_addr != '0);
    assign rs_hit = id_uses_rs & (id_rs_addr == ex_rt_addr);
    assign rt_hit = id_uses_rt & (id_rt_addr == ex_rt_addr);
    assign hazard = load_live & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and WB bypass.
// Optional perf counters enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int REG_AW = pipe_pkg::REG_AW_DEF,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush_i,
    input  logic              ex_stall_i,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs_addr,
    output logic [REG_AW-1:0] ex_rt_addr,
    output logic [REG_AW-1:0] ex_dst_addr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              hazard_o,
    output logic              stall_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    import pipe_pkg::*;

    logic              hazard;
    logic              wb_live;
    logic              byp_rs;
    logic              byp_rt;
    logic              hold_rs;
    logic              hold_rt;
    logic              bubble;
    logic [REG_AW-1:0] id_dst;
    logic [CTRL_W-1:0] id_ctrl_q;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_lud (
        .id_valid    (id_valid),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[MEMREAD]),
        .ex_rt_addr  (ex_rt_addr),
        .hazard      (hazard)
    );

    assign hazard_o = hazard;
    assign stall_o  = hazard | ex_stall_i;

    // $0 writes are architecturally discarded, so never bypass them
    assign wb_live = wb_reg_write & (wb_rd_addr != '0);
    assign byp_rs  = wb_live & (wb_rd_addr == id_rs_addr);
    assign byp_rt  = wb_live & (wb_rd_addr == id_rt_addr);
    assign hold_rs = wb_live & (wb_rd_addr == ex_rs_addr);
    assign hold_rt = wb_live & (wb_rd_addr == ex_rt_addr);

    // flush beats stall; a hazard only bubbles when EX can advance
    assign bubble = flush_i | (~ex_stall_i & hazard);

    // Select the destination from the control that will enter EX
    always_comb begin
        id_ctrl_q = id_valid ? id_ctrl : CTRL_NOP;
        id_dst    = '0;
        if (id_ctrl_q[REGWRITE]) begin
            id_dst = id_ctrl_q[REGDST] ? id_rd_addr : id_rt_addr;
        end
    end

    // Pipeline register: bubble, hold with WB refresh, or load from ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rs_addr  <= '0;
            ex_rt_addr  <= '0;
            ex_dst_addr <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= CTRL_NOP;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_rs_addr  <= '0;
            ex_rt_addr  <= '0;
            ex_dst_addr <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= CTRL_NOP;
        end else if (ex_stall_i) begin
            if (hold_rs) ex_rs_data <= wb_data;
            if (hold_rt) ex_rt_data <= wb_data;
        end else begin
            ex_valid    <= id_valid;
            ex_rs_addr  <= id_rs_addr;
            ex_rt_addr  <= id_rt_addr;
            ex_dst_addr <= id_dst;
            ex_rs_data  <= byp_rs ? wb_data : id_rs_data;
            ex_rt_data  <= byp_rt ? wb_data : id_rt_data;
            ex_imm      <= id_imm;
            ex_ctrl     <= id_ctrl_q;
        end
    end

`ifdef ID_EX_PERF_EN
    logic bubble_evt;
    logic flush_evt;

    assign bubble_evt = hazard & ~ex_stall_i & ~flush_i;
    assign flush_evt  = flush_i & id_valid;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (bubble_evt && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (flush_evt && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus flush
// and asynchronous reset sequences.
module tb_id_ex_stage;

    localparam logic       T   = 1'b1;
    localparam logic       F   = 1'b0;
    localparam logic [8:0] LW  = 9'h1B0;
    localparam logic [8:0] RT  = 9'h10A;
    localparam logic [8:0] RD0 = 9'h00A;
    localparam logic [8:0] SW  = 9'h040;
    localparam logic [8:0] NOP = 9'h000;

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic        urs, urt;
        logic [31:0] rsd, rtd, imm;
        logic [8:0]  c;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        fl, st;
    } in_t;

    typedef struct {
        logic        hz, sl, v;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsd, rtd, imm;
        logic [8:0]  c;
    } ex_t;

    typedef struct {
        in_t i;
        ex_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [8:0]  id_ctrl;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        flush_i, ex_stall_i;
    logic        ex_valid;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dst_addr;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [8:0]  ex_ctrl;
    logic        hazard_o, stall_o;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_bub = 0;
    int exp_fl = 0;
    vec_t tv[22];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rd_addr   (id_rd_addr),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .wb_reg_write (wb_reg_write),
        .wb_rd_addr   (wb_rd_addr),
        .wb_data      (wb_data),
        .flush_i      (flush_i),
        .ex_stall_i   (ex_stall_i),
        .ex_valid     (ex_valid),
        .ex_rs_addr   (ex_rs_addr),
        .ex_rt_addr   (ex_rt_addr),
        .ex_dst_addr  (ex_dst_addr),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_ctrl      (ex_ctrl),
        .hazard_o     (hazard_o),
        .stall_o      (stall_o)
`ifdef ID_EX_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    function automatic in_t mk_in(
        logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
        logic urs, logic urt,
        logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
        logic [8:0] c, logic we, logic [4:0] wrd, logic [31:0] wd,
        logic fl, logic st);
        in_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.rd = rd;
        r.urs = urs; r.urt = urt;
        r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.c = c;
        r.we = we; r.wrd = wrd; r.wd = wd;
        r.fl = fl; r.st = st;
        return r;
    endfunction

    function automatic ex_t mk_ex(
        logic hz, logic sl, logic v,
        logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
        logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
        logic [8:0] c);
        ex_t r;
        r.hz = hz; r.sl = sl; r.v = v;
        r.rs = rs; r.rt = rt; r.dst = dst;
        r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.c = c;
        return r;
    endfunction

    task automatic drive(input in_t i);
        id_valid     = i.v;
        id_rs_addr   = i.rs;
        id_rt_addr   = i.rt;
        id_rd_addr   = i.rd;
        id_uses_rs   = i.urs;
        id_uses_rt   = i.urt;
        id_rs_data   = i.rsd;
        id_rt_data   = i.rtd;
        id_imm       = i.imm;
        id_ctrl      = i.c;
        wb_reg_write = i.we;
        wb_rd_addr   = i.wrd;
        wb_data      = i.wd;
        flush_i      = i.fl;
        ex_stall_i   = i.st;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input ex_t e);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(e.v));
        chk({tag, ".rs"}, 32'(ex_rs_addr), 32'(e.rs));
        chk({tag, ".rt"}, 32'(ex_rt_addr), 32'(e.rt));
        chk({tag, ".dst"}, 32'(ex_dst_addr), 32'(e.dst));
        chk({tag, ".rsd"}, ex_rs_data, e.rsd);
        chk({tag, ".rtd"}, ex_rt_data, e.rtd);
        chk({tag, ".imm"}, ex_imm, e.imm);
        chk({tag, ".ctrl"}, 32'(ex_ctrl), 32'(e.c));
    endtask

    initial begin
        in_t z;
        in_t a;
        ex_t zero_ex;
        z = mk_in(F, 0, 0, 0, F, F, 0, 0, 0, NOP, F, 0, 0, F, F);
        zero_ex = mk_ex(F, F, F, 0, 0, 0, 0, 0, 0, NOP);

        // lw $8 then dependent add: one bubble, then the add
        tv[0].i  = mk_in(T, 2, 8, 0, T, F, 32'h100, 0, 4, LW,
                         F, 0, 0, F, F);
        tv[0].e  = mk_ex(F, F, T, 2, 8, 8, 32'h100, 0, 4, LW);
        tv[1].i  = mk_in(T, 8, 1, 9, T, T, 32'hAAAA, 5, 0, RT,
                         F, 0, 0, F, F);
        tv[1].e  = mk_ex(T, T, F, 0, 0, 0, 0, 0, 0, NOP);
        tv[2].i  = tv[1].i;
        tv[2].e  = mk_ex(F, F, T, 8, 1, 9, 32'hAAAA, 5, 0, RT);
        // lw $0 followed by reader of $0: no hazard
        tv[3].i  = mk_in(T, 3, 0, 0, T, F, 32'h30, 0, 8, LW,
                         F, 0, 0, F, F);
        tv[3].e  = mk_ex(F, F, T, 3, 0, 0, 32'h30, 0, 8, LW);
        tv[4].i  = mk_in(T, 0, 0, 10, T, T, 0, 0, 0, RT,
                         F, 0, 0, F, F);
        tv[4].e  = mk_ex(F, F, T, 0, 0, 10, 0, 0, 0, RT);
        // WB bypass into Rs
        tv[5].i  = mk_in(T, 5, 6, 11, T, T, 32'h11111111,
                         32'h22222222, 0, RT,
                         T, 5, 32'hDEADBEEF, F, F);
        tv[5].e  = mk_ex(F, F, T, 5, 6, 11, 32'hDEADBEEF,
                         32'h22222222, 0, RT);
        // WB to $0 must not bypass
        tv[6].i  = mk_in(T, 0, 4, 1, T, T, 0, 32'h44, 0, RT,
                         T, 0, 32'hFFFF, F, F);
        tv[6].e  = mk_ex(F, F, T, 0, 4, 1, 0, 32'h44, 0, RT);
        // WB address match without write enable
        tv[7].i  = mk_in(T, 7, 7, 2, T, T, 32'h70, 32'h71, 0, RT,
                         F, 7, 32'hBAD, F, F);
        tv[7].e  = mk_ex(F, F, T, 7, 7, 2, 32'h70, 32'h71, 0, RT);
        // destination select
        tv[8].i  = mk_in(T, 1, 3, 12, T, T, 1, 3, 0, RT,
                         F, 0, 0, F, F);
        tv[8].e  = mk_ex(F, F, T, 1, 3, 12, 1, 3, 0, RT);
        tv[9].i  = mk_in(T, 1, 3, 12, T, T, 1, 3, 0, RD0,
                         F, 0, 0, F, F);
        tv[9].e  = mk_ex(F, F, T, 1, 3, 0, 1, 3, 0, RD0);
        // invalid ID slot loads as NOP control
        tv[10].i = mk_in(F, 4, 5, 6, T, T, 9, 32'hA, 32'hC, SW,
                         F, 0, 0, F, F);
        tv[10].e = mk_ex(F, F, F, 4, 5, 0, 9, 32'hA, 32'hC, NOP);
        // load-use through Rt
        tv[11].i = mk_in(T, 1, 7, 0, T, F, 32'h10, 0, 0, LW,
                         F, 0, 0, F, F);
        tv[11].e = mk_ex(F, F, T, 1, 7, 7, 32'h10, 0, 0, LW);
        tv[12].i = mk_in(T, 9, 7, 0, F, T, 32'h90, 32'h97, 0, SW,
                         F, 0, 0, F, F);
        tv[12].e = mk_ex(T, T, F, 0, 0, 0, 0, 0, 0, NOP);
        // downstream stall for 3 cycles, WB refresh of Rt in cycle 2
        tv[13].i = mk_in(T, 3, 7, 13, T, T, 32'h33, 32'h77, 5, RT,
                         F, 0, 0, F, F);
        tv[13].e = mk_ex(F, F, T, 3, 7, 13, 32'h33, 32'h77, 5, RT);
        tv[14].i = mk_in(T, 1, 2, 4, T, T, 32'hE1, 32'hE2, 32'hE3,
                         RT, F, 0, 0, F, T);
        tv[14].e = mk_ex(F, T, T, 3, 7, 13, 32'h33, 32'h77, 5, RT);
        tv[15].i = mk_in(T, 1, 2, 4, T, T, 32'hE1, 32'hE2, 32'hE3,
                         RT, T, 7, 32'h12345678, F, T);
        tv[15].e = mk_ex(F, T, T, 3, 7, 13, 32'h33,
                         32'h12345678, 5, RT);
        tv[16].i = tv[14].i;
        tv[16].e = tv[15].e;
        tv[17].i = mk_in(T, 1, 2, 4, T, T, 32'hE1, 32'hE2, 32'hE3,
                         RT, F, 0, 0, F, F);
        tv[17].e = mk_ex(F, F, T, 1, 2, 4, 32'hE1, 32'hE2,
                         32'hE3, RT);
        // stall outranks hazard; refresh of held load Rt
        tv[18].i = mk_in(T, 0, 6, 0, T, F, 0, 0, 32'h20, LW,
                         F, 0, 0, F, F);
        tv[18].e = mk_ex(F, F, T, 0, 6, 6, 0, 0, 32'h20, LW);
        tv[19].i = mk_in(T, 6, 0, 5, T, F, 32'h60, 0, 0, RT,
                         T, 6, 32'h66, F, T);
        tv[19].e = mk_ex(T, T, T, 0, 6, 6, 0, 32'h66, 32'h20, LW);
        tv[20].i = mk_in(T, 6, 0, 5, T, F, 32'h60, 0, 0, RT,
                         F, 0, 0, F, F);
        tv[20].e = mk_ex(T, T, F, 0, 0, 0, 0, 0, 0, NOP);
        tv[21].i = tv[20].i;
        tv[21].e = mk_ex(F, F, T, 6, 0, 5, 32'h60, 0, 0, RT);

        rst_n = 1'b0;
        drive(z);
        #12;
        chk_regs("reset", zero_ex);
        chk("reset.hazard", 32'(hazard_o), 0);
        chk("reset.stall", 32'(stall_o), 0);
`ifdef ID_EX_PERF_EN
        chk("reset.pbub", perf_bubble_cnt, 0);
        chk("reset.pfl", perf_flush_cnt, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 22; k++) begin
            drive(tv[k].i);
            if (tv[k].e.hz && !tv[k].i.st && !tv[k].i.fl)
                exp_bub++;
            if (tv[k].i.fl && tv[k].i.v)
                exp_fl++;
            @(negedge clk);
            chk($sformatf("v%0d.hazard", k), 32'(hazard_o),
                32'(tv[k].e.hz));
            chk($sformatf("v%0d.stall", k), 32'(stall_o),
                32'(tv[k].e.sl));
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", k), tv[k].e);
        end

        // flush with hazard and stall together: bubble wins
        a = mk_in(T, 0, 8, 0, T, F, 0, 0, 0, LW, F, 0, 0, F, F);
        drive(a);
        @(posedge clk);
        #1;
        chk("fl.setup_rt", 32'(ex_rt_addr), 8);
        a = mk_in(T, 8, 1, 9, T, T, 32'h5, 32'h6, 0, RT,
                  F, 0, 0, T, T);
        drive(a);
        exp_fl++;
        @(negedge clk);
        chk("fl.hazard", 32'(hazard_o), 1);
        chk("fl.stall", 32'(stall_o), 1);
        @(posedge clk);
        #1;
        chk_regs("fl", zero_ex);
`ifdef ID_EX_PERF_EN
        chk("perf.bubble", perf_bubble_cnt, 32'(exp_bub));
        chk("perf.flush", perf_flush_cnt, 32'(exp_fl));
`endif

        // asynchronous reset mid-operation
        a = mk_in(T, 3, 4, 5, T, T, 32'h55, 32'h66, 0, RT,
                  F, 0, 0, F, F);
        drive(a);
        @(posedge clk);
        #1;
        chk("ar.pre_valid", 32'(ex_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("ar", zero_ex);
`ifdef ID_EX_PERF_EN
        chk("ar.pbub", perf_bubble_cnt, 0);
        chk("ar.pfl", perf_flush_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar.held_valid", 32'(ex_valid), 0);
        @(posedge clk);
        #1;
        chk("ar.reload_valid", 32'(ex_valid), 1);
        chk("ar.reload_rsd", ex_rs_data, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
